// File: rtl/pipe_stage_buf_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf_pkg
// Shared pipeline definitions used by every inter-stage buffer:
//   * stage_state_e : occupancy state of a stage buffer (EMPTY/ONE/TWO)
//   * default payload widths for each stage boundary (IF/ID .. MEM/WB)
//   * occ_of()      : maps a buffer state to its entry count
// -----------------------------------------------------------------------------
package pipe_stage_buf_pkg;

    // Encoding is significant: the numeric value equals the number of held
    // entries, which keeps the occupancy output trivially derivable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    // Generic defaults for a stage buffer.
    localparam int PIPE_DEF_DATA_W = 16;
    localparam int PIPE_DEF_CTRL_W = 8;

    // Per-boundary payload widths. DATA carries PC/immediates/operands and is
    // never cleared; CTRL carries side-effecting bits that are zeroed on a
    // bubble.
    localparam int IF_ID_DATA_W  = 32;  // PC + fetched instruction word
    localparam int IF_ID_CTRL_W  = 1;   // predicted-taken flag
    localparam int ID_EX_DATA_W  = 48;  // PC + two operands
    localparam int ID_EX_CTRL_W  = 8;   // alu op, mem_read/write, write_reg, halt
    localparam int EX_MEM_DATA_W = 32;  // alu result + store data
    localparam int EX_MEM_CTRL_W = 6;   // mem_read/write, write_reg, halt, dest
    localparam int MEM_WB_DATA_W = 16;  // writeback value
    localparam int MEM_WB_CTRL_W = 4;   // write_reg, halt, dest

    // Number of entries held in a given state.
    function automatic logic [1:0] occ_of(input stage_state_e s);
        logic [1:0] n;
        case (s)
            ST_EMPTY: n = 2'd0;
            ST_ONE:   n = 2'd1;
            ST_TWO:   n = 2'd2;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage : pipe_stage_buf_pkg

// File: rtl/pipe_stage_buf_pldff.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf_pldff
// Pipeline load-enabled D flip-flop bank with asynchronous active-low clear.
// Used for both the main (output) register and the skid register of a stage
// buffer.
//
// Ports:
//   clk   in   1   clock, state changes on rising edge
//   rst   in   1   asynchronous active-low clear (contents -> 0)
//   i_en  in   1   load enable
//   i_d   in   W   value loaded when i_en is high
//   o_q   out  W   current register contents
// -----------------------------------------------------------------------------
module pipe_stage_buf_pldff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_stage_buf_pldff

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Valid/ready pipeline stage buffer between two processor stages.
//
// SKID=1: two-entry skid buffer. in_ready is registered, so out_ready never
//         reaches in_ready combinationally; full throughput with a cut ready
//         path.
// SKID=0: single register. in_ready = out_ready | !out_valid (combinational).
//
// flush squashes every held entry and any entry arriving that cycle. While
// out_valid is low, out_ctrl is forced to zero so a bubble can never trigger
// a side effect downstream; out_data keeps its last value.
//
// Parameters:
//   DATA_W  payload bits kept across bubbles
//   CTRL_W  control bits zeroed on bubbles
//   SKID    1 = two-entry skid mode, 0 = single-register mode
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-low reset
//   in_valid   in   1       upstream has a valid entry
//   in_ready   out  1       this stage accepts the entry this cycle
//   in_ctrl    in   CTRL_W  upstream control bits
//   in_data    in   DATA_W  upstream data bits
//   flush      in   1       synchronous squash (branch mispredict)
//   out_valid  out  1       downstream payload valid
//   out_ready  in   1       downstream accepts this cycle
//   out_ctrl   out  CTRL_W  held control bits (zero when not valid)
//   out_data   out  DATA_W  held data bits
//   occupancy  out  2       number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W = PIPE_DEF_DATA_W,
    parameter int CTRL_W = PIPE_DEF_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Entries are stored as {ctrl, data}.
    localparam int ENT_W = CTRL_W + DATA_W;

    stage_state_e     r_state;
    stage_state_e     w_state_next;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_en;
    logic             w_skid_en;
    logic             w_main_sel_skid;
    logic [ENT_W-1:0] w_in_entry;
    logic [ENT_W-1:0] w_main_d;
    logic [ENT_W-1:0] w_main_q;
    logic [ENT_W-1:0] w_skid_q;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign w_in_entry  = {in_ctrl, in_data};
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and register load controls
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_main_en       = 1'b0;
        w_skid_en       = 1'b0;
        w_main_sel_skid = 1'b0;

        if (flush) begin
            // Squash wins over every transfer. Registers are left untouched:
            // ctrl is masked by out_valid and data is allowed to go stale.
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_next = ST_ONE;
                        w_main_en    = 1'b1;
                    end
                end

                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        // Head leaves and the new entry replaces it directly.
                        w_main_en = 1'b1;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the arrival in the skid.
                        // In single-register mode in_ready already implies
                        // out_fire here, so this branch is never taken.
                        if (SKID != 0) begin
                            w_state_next = ST_TWO;
                            w_skid_en    = 1'b1;
                        end
                    end else if (w_out_fire) begin
                        w_state_next = ST_EMPTY;
                    end
                end

                ST_TWO: begin
                    // in_ready is low in this state, so only a drain can occur.
                    if (w_out_fire) begin
                        w_state_next    = ST_ONE;
                        w_main_en       = 1'b1;
                        w_main_sel_skid = 1'b1;
                    end
                end

                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_main_d = w_main_sel_skid ? w_skid_q : w_in_entry;

    // -------------------------------------------------------------------------
    // Main (output) register
    // -------------------------------------------------------------------------
    pipe_stage_buf_pldff #(
        .W (ENT_W)
    ) u_main_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_main_en),
        .i_d  (w_main_d),
        .o_q  (w_main_q)
    );

    // -------------------------------------------------------------------------
    // Mode-specific ready generation and skid storage
    // -------------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;

            // Registered ready: computed from the next state so it is already
            // low in the cycle the buffer becomes full.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_next != ST_TWO);
                end
            end

            assign w_in_ready = r_in_ready;

            pipe_stage_buf_pldff #(
                .W (ENT_W)
            ) u_skid_reg (
                .clk  (clk),
                .rst  (rst),
                .i_en (w_skid_en),
                .i_d  (w_in_entry),
                .o_q  (w_skid_q)
            );
        end else begin : g_noskid
            // Accept whenever the held entry is leaving or nothing is held.
            assign w_in_ready = out_ready | ~w_out_valid;
            assign w_skid_q   = '0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_bubble
            // A bubble presents all-zero control bits.
            assign out_ctrl[gi] = w_main_q[DATA_W + gi] & w_out_valid;
        end
    endgenerate

    assign out_data  = w_main_q[DATA_W-1:0];
    assign out_valid = w_out_valid;
    assign in_ready  = w_in_ready;
    assign occupancy = occ_of(r_state);

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
// Directed bench for pipe_stage_buf: one instance in skid mode (a_*), one in
// single-register mode (b_*). Inputs change 1 ns after a rising edge and
// outputs are checked in the same window, away from the active edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk;
    logic          rst;

    logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occ;

    logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occ;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_ctrl   (a_in_ctrl),
        .in_data   (a_in_data),
        .flush     (a_flush),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_ctrl  (a_out_ctrl),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_ctrl   (b_in_ctrl),
        .in_data   (b_in_data),
        .flush     (b_flush),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_ctrl  (b_out_ctrl),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks valid/ctrl/occupancy of the skid instance in one call.
    task automatic chk_a(input string tag, input logic v, input logic [7:0] c, input logic [1:0] o);
        chk({tag, ".a_valid"}, {31'd0, a_out_valid}, {31'd0, v});
        chk({tag, ".a_ctrl"},  {24'd0, a_out_ctrl},  {24'd0, c});
        chk({tag, ".a_occ"},   {30'd0, a_occ},       {30'd0, o});
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [7:0] c, input logic [1:0] o);
        chk({tag, ".b_valid"}, {31'd0, b_out_valid}, {31'd0, v});
        chk({tag, ".b_ctrl"},  {24'd0, b_out_ctrl},  {24'd0, c});
        chk({tag, ".b_occ"},   {30'd0, b_occ},       {30'd0, o});
    endtask

    task automatic drive_a(input logic v, input logic [7:0] c, input logic [15:0] d);
        a_in_valid = v;
        a_in_ctrl  = c;
        a_in_data  = d;
    endtask

    // Safety net against a hang; never reached in a normal run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive_a(1'b0, 8'h00, 16'h0000);
        a_flush = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0;
        b_flush = 1'b0; b_out_ready = 1'b1;

        // ---------------- reset state ----------------
        #1 rst = 1'b0;
        #2;
        chk_a("reset", 1'b0, 8'h00, 2'd0);
        chk("reset.a_ready", {31'd0, a_in_ready}, 32'd1);
        chk("reset.a_data",  {16'd0, a_out_data}, 32'd0);
        chk_b("reset", 1'b0, 8'h00, 2'd0);
        #9 rst = 1'b1;                                   // t=12, between edges

        // ---------------- streaming 01..04 ----------------
        a_out_ready = 1'b1;
        drive_a(1'b1, 8'h01, 16'h1001);
        tick(); chk_a("stream1", 1'b1, 8'h01, 2'd1);
        drive_a(1'b1, 8'h02, 16'h1002);
        tick(); chk_a("stream2", 1'b1, 8'h02, 2'd1);
        drive_a(1'b1, 8'h03, 16'h1003);
        tick(); chk_a("stream3", 1'b1, 8'h03, 2'd1);
        drive_a(1'b1, 8'h04, 16'h1004);
        tick(); chk_a("stream4", 1'b1, 8'h04, 2'd1);
        chk("stream4.data", {16'd0, a_out_data}, 32'h1004);
        drive_a(1'b0, 8'h00, 16'h0000);
        tick(); chk_a("bubble", 1'b0, 8'h00, 2'd0);
        chk("bubble.data_hold", {16'd0, a_out_data}, 32'h1004);

        // ---------------- stall A1,A2,A3 ----------------
        a_out_ready = 1'b0;
        drive_a(1'b1, 8'hA1, 16'h00A1);
        tick(); chk_a("stall1", 1'b1, 8'hA1, 2'd1);
        chk("stall1.ready", {31'd0, a_in_ready}, 32'd1);
        drive_a(1'b1, 8'hA2, 16'h00A2);
        tick(); chk_a("stall2", 1'b1, 8'hA1, 2'd2);
        chk("stall2.ready", {31'd0, a_in_ready}, 32'd0);
        drive_a(1'b1, 8'hA3, 16'h00A3);
        tick(); chk_a("stall3", 1'b1, 8'hA1, 2'd2);
        chk("stall3.ready", {31'd0, a_in_ready}, 32'd0);
        chk("stall3.data",  {16'd0, a_out_data}, 32'h00A1);
        a_out_ready = 1'b1;
        tick(); chk_a("drain1", 1'b1, 8'hA2, 2'd1);
        chk("drain1.data",  {16'd0, a_out_data}, 32'h00A2);
        chk("drain1.ready", {31'd0, a_in_ready}, 32'd1);
        tick(); chk_a("drain2", 1'b1, 8'hA3, 2'd1);
        chk("drain2.data", {16'd0, a_out_data}, 32'h00A3);
        drive_a(1'b0, 8'h00, 16'h0000);
        tick(); chk_a("drain3", 1'b0, 8'h00, 2'd0);

        // ---------------- flush from TWO ----------------
        a_out_ready = 1'b0;
        drive_a(1'b1, 8'hB1, 16'h00B1);
        tick();
        drive_a(1'b1, 8'hB2, 16'h00B2);
        tick(); chk_a("fill2", 1'b1, 8'hB1, 2'd2);
        a_flush = 1'b1;
        drive_a(1'b1, 8'hB3, 16'h00B3);
        tick(); chk_a("flush2", 1'b0, 8'h00, 2'd0);
        chk("flush2.ready", {31'd0, a_in_ready}, 32'd1);
        a_flush = 1'b0;

        // ---------------- flush from ONE with in_fire ----------------
        drive_a(1'b1, 8'hC1, 16'h00C1);
        tick(); chk_a("fill1", 1'b1, 8'hC1, 2'd1);
        a_flush = 1'b1;
        drive_a(1'b1, 8'hC2, 16'h00C2);                  // accepted but squashed
        tick(); chk_a("flush1", 1'b0, 8'h00, 2'd0);
        a_flush = 1'b0;
        drive_a(1'b0, 8'h00, 16'h0000);
        tick(); chk_a("flush1.after", 1'b0, 8'h00, 2'd0);
        a_out_ready = 1'b1;
        drive_a(1'b1, 8'hD1, 16'h00D1);
        tick(); chk_a("post_flush", 1'b1, 8'hD1, 2'd1);
        chk("post_flush.data", {16'd0, a_out_data}, 32'h00D1);
        drive_a(1'b0, 8'h00, 16'h0000);
        tick();

        // ---------------- async reset mid-cycle ----------------
        a_out_ready = 1'b0;
        drive_a(1'b1, 8'hE5, 16'hBEEF);
        tick();
        drive_a(1'b1, 8'hE6, 16'hCAFE);
        tick(); chk_a("pre_rst", 1'b1, 8'hE5, 2'd2);
        chk("pre_rst.data", {16'd0, a_out_data}, 32'hBEEF);
        drive_a(1'b0, 8'h00, 16'h0000);
        #2 rst = 1'b0;                                   // no clock edge nearby
        #1;
        chk_a("async_rst", 1'b0, 8'h00, 2'd0);
        chk("async_rst.data",  {16'd0, a_out_data}, 32'd0);
        chk("async_rst.ready", {31'd0, a_in_ready}, 32'd1);
        #2 rst = 1'b1;
        a_out_ready = 1'b1;
        drive_a(1'b1, 8'hF1, 16'h00F1);
        tick(); chk_a("rst_release", 1'b1, 8'hF1, 2'd1);
        chk("rst_release.data", {16'd0, a_out_data}, 32'h00F1);
        drive_a(1'b0, 8'h00, 16'h0000);
        tick(); chk_a("rst_release.empty", 1'b0, 8'h00, 2'd0);

        // ---------------- single-register mode ----------------
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_ctrl = 8'h11; b_in_data = 16'h0011;
        #1 chk("s0.ready_empty", {31'd0, b_in_ready}, 32'd1);
        tick(); chk_b("s0_1", 1'b1, 8'h11, 2'd1);
        b_in_ctrl = 8'h12; b_in_data = 16'h0012; b_out_ready = 1'b1;
        #1 chk("s0.ready_hi", {31'd0, b_in_ready}, 32'd1);
        tick(); chk_b("s0_2", 1'b1, 8'h12, 2'd1);
        b_in_ctrl = 8'h13; b_in_data = 16'h0013; b_out_ready = 1'b0;
        #1 chk("s0.ready_lo", {31'd0, b_in_ready}, 32'd0);
        tick(); chk_b("s0_stall", 1'b1, 8'h12, 2'd1);
        chk("s0_stall.data", {16'd0, b_out_data}, 32'h0012);
        b_out_ready = 1'b1;
        #1 chk("s0.ready_back", {31'd0, b_in_ready}, 32'd1);
        tick(); chk_b("s0_3", 1'b1, 8'h13, 2'd1);
        b_in_valid = 1'b0;
        tick(); chk_b("s0_empty", 1'b0, 8'h00, 2'd0);
        chk("s0_empty.data", {16'd0, b_out_data}, 32'h0013);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_stage_buf
